// File: rtl/receptor_morse_pkg.sv
// Shared definitions for the Morse receiver: FSM state encoding and
// character / gap geometry expressed in Morse units.
package receptor_morse_pkg;

  typedef enum logic [1:0] {
    REPOSO,
    ALINEAR,
    MUESTREO,
    ESPERA
  } estado_t;

  localparam int unsigned ANCHO_CARAC = 27;
  localparam int unsigned MAX_CARAC   = 12;
  localparam int unsigned GAP_CARAC   = 3;
  localparam int unsigned GAP_MENSAJE = 7;

endpackage

// File: rtl/contador_unidad.sv
// Unit-tick prescaler: tick is high for one cycle every CICLOS_UNIDAD cycles,
// counted from the cycle after reinicio.
module contador_unidad #(
  parameter int unsigned CICLOS_UNIDAD = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic reinicio,
  output logic tick
);

  logic [7:0] cuenta;

  always_ff @(posedge CLK) begin
    if (RST || reinicio || tick) cuenta <= '0;
    else                         cuenta <= cuenta + 8'd1;
  end

  assign tick = (cuenta == 8'(CICLOS_UNIDAD - 1));

endmodule

// File: rtl/receptor_morse.sv
// Morse receiver: samples a synchronized tone line once per unit, assembles
// left-aligned character patterns and reports characters, errors and message end.
module receptor_morse
  import receptor_morse_pkg::*;
#(
  parameter int unsigned CICLOS_UNIDAD = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        entrada,
  output logic [26:0] datos,
  output logic [3:0]  conta_carac,
  output logic        dato_valido,
  output logic        fin_mensaje,
  output logic        error,
  output logic        lleno
);

  localparam logic [7:0] MEDIA = 8'(CICLOS_UNIDAD / 2 - 1);

  estado_t     estado;
  logic        s1, s2, s3;
  logic        flanco;
  logic [7:0]  cnt_alinear;
  logic [2:0]  cnt_gap;
  logic [26:0] sr;
  logic [4:0]  nbits;
  logic [1:0]  ceros;
  logic [4:0]  suma;
  logic        descartar;
  logic        reinicio;
  logic        tick;

  contador_unidad #(.CICLOS_UNIDAD(CICLOS_UNIDAD)) u_contador (
    .CLK      (CLK),
    .RST      (RST),
    .reinicio (reinicio),
    .tick     (tick)
  );

  assign flanco   = s2 & ~s3;
  assign reinicio = (estado == ALINEAR) && (cnt_alinear == MEDIA);
  // Length after flushing pending zeros plus the new 1; exceeding the width is an error.
  assign suma     = nbits + {3'b000, ceros} + 5'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      estado      <= REPOSO;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cnt_alinear <= '0;
      cnt_gap     <= '0;
      sr          <= '0;
      nbits       <= '0;
      ceros       <= '0;
      descartar   <= 1'b0;
      datos       <= '0;
      conta_carac <= '0;
      dato_valido <= 1'b0;
      fin_mensaje <= 1'b0;
      error       <= 1'b0;
      lleno       <= 1'b0;
    end else begin
      s1          <= entrada;
      s2          <= s1;
      s3          <= s2;
      dato_valido <= 1'b0;
      fin_mensaje <= 1'b0;
      error       <= 1'b0;

      // Index advances right after it was presented; saturates and raises lleno.
      if (dato_valido) begin
        if (conta_carac == 4'(MAX_CARAC - 1)) lleno <= 1'b1;
        else                                  conta_carac <= conta_carac + 4'd1;
      end

      case (estado)
        REPOSO, ESPERA: begin
          if (flanco) begin
            estado      <= ALINEAR;
            cnt_alinear <= '0;
            sr          <= '0;
            nbits       <= '0;
            ceros       <= '0;
            descartar   <= 1'b0;
            if (estado == REPOSO) begin
              conta_carac <= '0;
              lleno       <= 1'b0;
            end
          end else if (estado == ESPERA && tick) begin
            if (cnt_gap == 3'(GAP_MENSAJE - 1)) begin
              fin_mensaje <= 1'b1;
              estado      <= REPOSO;
            end else begin
              cnt_gap <= cnt_gap + 3'd1;
            end
          end
        end

        ALINEAR: begin
          if (cnt_alinear == MEDIA) begin
            estado <= MUESTREO;
            sr     <= 27'd1;
            nbits  <= 5'd1;
          end else begin
            cnt_alinear <= cnt_alinear + 8'd1;
          end
        end

        MUESTREO: begin
          if (tick) begin
            if (s2) begin
              ceros <= '0;
              if (!descartar) begin
                if (suma > 5'(ANCHO_CARAC)) begin
                  error     <= 1'b1;
                  descartar <= 1'b1;
                end else begin
                  sr    <= (sr << (ceros + 2'd1)) | 27'd1;
                  nbits <= suma;
                end
              end
            end else if (ceros == 2'(GAP_CARAC - 1)) begin
              estado  <= ESPERA;
              cnt_gap <= '0;
              if (!descartar && !lleno) begin
                dato_valido <= 1'b1;
                datos       <= sr << (5'(ANCHO_CARAC) - nbits);
              end
            end else begin
              ceros <= ceros + 2'd1;
            end
          end
        end

        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_morse.sv
// Self-checking bench for receptor_morse: unit-level stimulus compared against
// a run-length reference model of characters, gaps and messages.
module tb_receptor_morse;

  localparam int unsigned CU  = 4;
  localparam int          LAT = 3 + CU / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        entrada;
  logic [26:0] datos;
  logic [3:0]  conta_carac;
  logic        dato_valido, fin_mensaje, error, lleno;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          kind;
    int          t;
    logic [26:0] d;
    logic [3:0]  idx;
  } ev_t;

  ev_t obs[$];
  ev_t expq[$];
  bit  seg[$];

  receptor_morse #(.CICLOS_UNIDAD(CU)) dut (
    .CLK         (clk),
    .RST         (rst),
    .entrada     (entrada),
    .datos       (datos),
    .conta_carac (conta_carac),
    .dato_valido (dato_valido),
    .fin_mensaje (fin_mensaje),
    .error       (error),
    .lleno       (lleno)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = dato_valido, 1 = error, 2 = fin_mensaje
  always @(negedge clk) begin
    if (!rst) begin
      if (dato_valido) obs.push_back('{kind: 0, t: cyc, d: datos, idx: conta_carac});
      if (error)       obs.push_back('{kind: 1, t: cyc, d: '0, idx: '0});
      if (fin_mensaje) obs.push_back('{kind: 2, t: cyc, d: '0, idx: '0});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic add(input bit b, input int n);
    for (int i = 0; i < n; i++) seg.push_back(b);
  endtask

  task automatic drive(output int c0);
    c0 = 0;
    for (int u = 0; u < seg.size(); u++)
      for (int k = 0; k < int'(CU); k++) begin
        @(posedge clk);
        if (k == 0) begin
          #1;
          entrada = seg[u];
          if (u == 0) c0 = cyc;
        end
      end
  endtask

  // Reference: a character is a run starting at a 1 and ending at its third
  // consecutive 0; a message ends when 7 further units pass with no tone.
  task automatic model(input int c0, output int dfin);
    int n, i, d, last_close, s, last1, z, k, e, close, m;
    logic [26:0] p;
    n = seg.size(); i = 0; d = 0; last_close = -100;
    while (i < n) begin
      if (!seg[i]) begin i++; continue; end
      if (i > last_close + 7) d = 0;
      s = i; last1 = i; z = 0; k = i + 1; e = -1;
      while (k < n && z < 3) begin
        if (seg[k]) begin
          last1 = k; z = 0;
          if (k - s >= 27 && e < 0) e = k;
        end else z++;
        k++;
      end
      if (z < 3) break;
      close = k - 1;
      if (e >= 0) expq.push_back('{kind: 1, t: c0 + int'(CU) * e + LAT, d: '0, idx: '0});
      else if (d < 12) begin
        p = '0;
        for (int b = s; b <= last1; b++) p[26 - (b - s)] = seg[b];
        expq.push_back('{kind: 0, t: c0 + int'(CU) * close + LAT, d: p, idx: 4'(d)});
        d++;
      end
      m = close + 1;
      while (m < n && !seg[m]) m++;
      if (m > close + 7 && close + 7 < n)
        expq.push_back('{kind: 2, t: c0 + int'(CU) * (close + 7) + LAT, d: '0, idx: '0});
      last_close = close;
      i = k;
    end
    dfin = d;
  endtask

  task automatic run_seg(input string name);
    int c0, dfin, nmin;
    obs.delete(); expq.delete();
    drive(c0);
    repeat (LAT + 4) @(posedge clk);
    #1;
    model(c0, dfin);
    chk({name, " events"}, obs.size(), expq.size());
    nmin = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int j = 0; j < nmin; j++) begin
      chk($sformatf("%s ev%0d kind", name, j), obs[j].kind, expq[j].kind);
      chk($sformatf("%s ev%0d time", name, j), obs[j].t, expq[j].t);
      chk($sformatf("%s ev%0d datos", name, j), 32'(obs[j].d), 32'(expq[j].d));
      chk($sformatf("%s ev%0d idx", name, j), 32'(obs[j].idx), 32'(expq[j].idx));
    end
    chk({name, " conta_carac"}, 32'(conta_carac), (dfin >= 12) ? 11 : dfin);
    chk({name, " lleno"}, 32'(lleno), (dfin >= 12) ? 1 : 0);
    seg.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, " datos"}, 32'(datos), 0);
    chk({name, " conta_carac"}, 32'(conta_carac), 0);
    chk({name, " dato_valido"}, 32'(dato_valido), 0);
    chk({name, " fin_mensaje"}, 32'(fin_mensaje), 0);
    chk({name, " error"}, 32'(error), 0);
    chk({name, " lleno"}, 32'(lleno), 0);
  endtask

  task automatic rand_char();
    int ne;
    if ($urandom_range(7) == 0) add(1'b1, $urandom_range(20, 32));
    else begin
      ne = $urandom_range(1, 5);
      for (int j = 0; j < ne; j++) begin
        if (j > 0) add(1'b0, 1);
        add(1'b1, ($urandom_range(1) == 1) ? 3 : 1);
      end
    end
  endtask

  initial begin
    int c0;
    rst = 1'b1; entrada = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    repeat (4) @(posedge clk);

    add(1'b1, 1); add(1'b0, 10);
    run_seg("E");
    chk("E obs datos", (obs.size() > 0) ? 32'(obs[0].d) : 32'hFFFF_FFFF, 32'h400_0000);
    chk("E fin gap", (obs.size() > 1) ? obs[1].t - obs[0].t : -1, 7 * int'(CU));

    seg.push_back(1'b1); seg.push_back(1'b0); add(1'b1, 3); add(1'b0, 10);
    run_seg("A");
    chk("A obs datos", (obs.size() > 0) ? 32'(obs[0].d) : 32'hFFFF_FFFF, 32'h5C0_0000);

    for (int j = 0; j < 13; j++) begin add(1'b1, 1); add(1'b0, 3); end
    add(1'b0, 10);
    run_seg("E x13");
    chk("E x13 lleno", 32'(lleno), 1);

    add(1'b1, 28); add(1'b0, 10); add(1'b1, 1); add(1'b0, 10);
    run_seg("overflow");

    add(1'b1, 1); add(1'b0, 10); add(1'b1, 1); add(1'b0, 10);
    run_seg("two msgs");

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < int'($urandom_range(3, 9)); c++) begin
        rand_char();
        add(1'b0, $urandom_range(3, 12));
      end
      add(1'b0, 10);
      run_seg($sformatf("rand%0d", r));
    end

    // Leave a nonzero index behind, then reset in the middle of an "A".
    add(1'b1, 1); add(1'b0, 10);
    run_seg("pre reset");
    obs.delete();
    seg.push_back(1'b1); seg.push_back(1'b0); seg.push_back(1'b1);
    drive(c0);
    @(posedge clk);
    #1 rst = 1'b1; entrada = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("mid reset");
    rst = 1'b0;
    seg.delete();
    repeat (20) @(posedge clk);
    chk("mid reset no events", obs.size(), 0);
    add(1'b1, 1); add(1'b0, 10);
    run_seg("E after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
